// File: rtl/pdm_pkg.sv
// Shared PDM constants: CIC order, accumulator sizing and bit polarity mapping.
// Both the PDM modulator and the CIC decimator import this package.
package pdm_pkg;

    localparam int unsigned CIC_ORDER = 3;

    localparam int signed PDM_POS = 1;
    localparam int signed PDM_NEG = -1;

    // Full-scale +/-DECIM^CIC_ORDER plus sign and one bit of headroom.
    function automatic int unsigned acc_w(input int unsigned decim);
        return CIC_ORDER * $clog2(decim) + 2;
    endfunction

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// PDM bit-stream input and PCM sample output of the CIC decimator.
// master = PDM front end / PCM consumer side, slave = decimator.
interface pdm_cic_decimator_if #(
    parameter int unsigned OUT_BITS = 16
);
    logic                       pdm_valid;
    logic                       pdm_in;
    logic signed [OUT_BITS-1:0] pcm_data;
    logic                       pcm_valid;

    modport master (output pdm_valid, output pdm_in, input pcm_data, input pcm_valid);
    modport slave  (input pdm_valid, input pdm_in, output pcm_data, output pcm_valid);
endinterface

// File: rtl/pdm_dc_block.sv
// First-order DC blocker, y = x - x' + y' - (y' >>> DC_SHIFT), one clk latency.
// The accumulator holds y scaled by 2^DC_SHIFT so the leak term keeps its fraction.
module pdm_dc_block #(
    parameter int unsigned OUT_BITS = 16,
    parameter int unsigned DC_SHIFT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [OUT_BITS-1:0] in_data,
    output logic                       out_valid,
    output logic signed [OUT_BITS-1:0] out_data
);
    localparam int unsigned W = OUT_BITS + DC_SHIFT;
    typedef logic signed [W-1:0] dcb_t;

    dcb_t                       acc_q, acc_d;
    logic signed [OUT_BITS-1:0] x_prev_q, x_prev_d;
    logic signed [OUT_BITS-1:0] out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;

    always_comb begin
        acc_d       = acc_q;
        x_prev_d    = x_prev_q;
        out_data_d  = out_data_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            acc_d      = acc_q + ((dcb_t'(in_data) - dcb_t'(x_prev_q)) <<< DC_SHIFT)
                         - (acc_q >>> DC_SHIFT);
            x_prev_d   = in_data;
            out_data_d = OUT_BITS'(acc_d >>> DC_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            x_prev_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            x_prev_q    <= x_prev_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/pdm_cic_decimator.sv
// 3rd-order CIC decimator: PDM bits in, signed PCM out, 4 clk frame-to-sample latency.
// Define PDM_CIC_DCBLOCK_EN to append a DC blocker (pdm_dc_block, +1 clk latency).
module pdm_cic_decimator
    import pdm_pkg::*;
#(
    parameter int unsigned DECIM    = 64,
    parameter int unsigned OUT_BITS = 16,
    parameter int unsigned DC_SHIFT = 8
) (
    input logic                clk,
    input logic                rst,
    pdm_cic_decimator_if.slave bus
);
    localparam int unsigned ACC_W = acc_w(DECIM);
    localparam int unsigned SHIFT = ACC_W - OUT_BITS;
    localparam int unsigned CNT_W = $clog2(DECIM);

    typedef logic signed [ACC_W-1:0] acc_t;

    if (DECIM < 8 || DECIM > 256 || (DECIM & (DECIM - 1)) != 0 ||
        OUT_BITS > ACC_W || DC_SHIFT == 0 || DC_SHIFT >= 32) begin : g_bad_params
        $error("pdm_cic_decimator: illegal parameter set");
    end

    acc_t                       integ_q [CIC_ORDER];
    acc_t                       integ_d [CIC_ORDER];
    acc_t                       dly_q   [CIC_ORDER];
    acc_t                       dly_d   [CIC_ORDER];
    acc_t                       comb_q  [CIC_ORDER];
    acc_t                       comb_d  [CIC_ORDER];
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [1:0]                 warm_q, warm_d;
    logic [CIC_ORDER:0]         vld_q, vld_d, emit_q, emit_d;
    logic signed [OUT_BITS-1:0] pcm_data_q, pcm_data_d;
    logic                       pcm_valid_q, pcm_valid_d;
    logic                       frame_done;
    acc_t                       in_term;
    acc_t                       comb_in;

    always_comb begin
        frame_done = bus.pdm_valid && (cnt_q == CNT_W'(DECIM - 1));
        in_term    = bus.pdm_in ? acc_t'(PDM_POS) : acc_t'(PDM_NEG);
        integ_d    = integ_q;
        cnt_d      = cnt_q;
        if (bus.pdm_valid) begin
            cnt_d      = cnt_q + 1'b1;
            integ_d[0] = integ_q[0] + in_term;
            for (int unsigned k = 1; k < CIC_ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_d[k-1];
            end
        end

        // Frames 1..CIC_ORDER still flow through the combs but are never emitted.
        warm_d = (frame_done && warm_q != 2'(CIC_ORDER)) ? warm_q + 2'd1 : warm_q;
        vld_d  = {vld_q[CIC_ORDER-1:0], frame_done};
        emit_d = {emit_q[CIC_ORDER-1:0], frame_done && (warm_q == 2'(CIC_ORDER))};

        // Stage k fires one clk after stage k-1; stage 0 reads the settled integrator.
        dly_d   = dly_q;
        comb_d  = comb_q;
        comb_in = '0;
        for (int unsigned k = 0; k < CIC_ORDER; k++) begin
            if (vld_q[k]) begin
                comb_in   = (k == 0) ? integ_q[CIC_ORDER-1] : comb_q[k-1];
                comb_d[k] = comb_in - dly_q[k];
                dly_d[k]  = comb_in;
            end
        end

        pcm_valid_d = vld_q[CIC_ORDER] && emit_q[CIC_ORDER];
        pcm_data_d  = pcm_valid_d ? OUT_BITS'(comb_q[CIC_ORDER-1] >>> SHIFT) : pcm_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ_q     <= '{default: '0};
            dly_q       <= '{default: '0};
            comb_q      <= '{default: '0};
            cnt_q       <= '0;
            warm_q      <= '0;
            vld_q       <= '0;
            emit_q      <= '0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            dly_q       <= dly_d;
            comb_q      <= comb_d;
            cnt_q       <= cnt_d;
            warm_q      <= warm_d;
            vld_q       <= vld_d;
            emit_q      <= emit_d;
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
        end
    end

`ifdef PDM_CIC_DCBLOCK_EN
    pdm_dc_block #(
        .OUT_BITS (OUT_BITS),
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_block (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pcm_valid_q),
        .in_data   (pcm_data_q),
        .out_valid (bus.pcm_valid),
        .out_data  (bus.pcm_data)
    );
`else
    assign bus.pcm_valid = pcm_valid_q;
    assign bus.pcm_data  = pcm_data_q;
`endif

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator at DECIM=64, OUT_BITS=16 with hand-computed outputs.
// Expected values follow PDM_CIC_DCBLOCK_EN when that macro is defined for the build.
module tb_pdm_cic_decimator;

    localparam int DECIM    = 64;
    localparam int OUT_BITS = 16;
`ifdef PDM_CIC_DCBLOCK_EN
    localparam int LAT      = 5;
    localparam int C1_LAST  = 16256;   // 3rd sample: 16384, 16320, 16256
    localparam int C0_LAST  = -16257;  // arithmetic shift floors -16256.25
    localparam int G3_LAST  = 16320;
`else
    localparam int LAT      = 4;
    localparam int C1_LAST  = 16384;
    localparam int C0_LAST  = -16384;
    localparam int G3_LAST  = 16384;
`endif

    logic clk = 1'b0;
    logic rst;

    pdm_cic_decimator_if #(.OUT_BITS(OUT_BITS)) bus ();

    pdm_cic_decimator #(
        .DECIM    (DECIM),
        .OUT_BITS (OUT_BITS),
        .DC_SHIFT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_strobe;
    int ev_cyc[$];
    int ev_val[$];
    int frm_edge[$];

    always @(negedge clk) begin
        if (bus.pcm_valid) begin
            ev_cyc.push_back(cyc);
            ev_val.push_back(int'(bus.pcm_data));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.pdm_valid = 1'b0;
        bus.pdm_in    = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        n_strobe = 0;
        ev_cyc.delete();
        ev_val.delete();
        frm_edge.delete();
    endtask

    // mode 0: all 1s, 1: all 0s, 2: alternating starting with 1
    task automatic drive(input int mode, input int gap, input int nstr);
        for (int i = 0; i < nstr; i++) begin
            @(negedge clk);
            bus.pdm_valid = 1'b1;
            bus.pdm_in    = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((n_strobe % 2) == 0);
            if ((n_strobe % DECIM) == DECIM - 1) frm_edge.push_back(cyc + 1);
            n_strobe++;
            for (int g = 1; g < gap; g++) begin
                @(negedge clk);
                bus.pdm_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.pdm_valid = 1'b0;
    endtask

    task automatic flush();
        repeat (10) @(negedge clk);
    endtask

    // Output k belongs to frame 4+k (frm_edge index 3+k).
    task automatic check_stream(input string tag, input int exp_n, input int v_first,
                                input int v_last);
        int n;
        n = ev_cyc.size();
        check({tag, "_count"}, n, exp_n);
        if (n == exp_n && n > 0 && frm_edge.size() >= 3 + n) begin
            check({tag, "_first"}, ev_val[0], v_first);
            check({tag, "_last"}, ev_val[n-1], v_last);
            check({tag, "_lat_first"}, ev_cyc[0] - frm_edge[3], LAT);
            check({tag, "_lat_last"}, ev_cyc[n-1] - frm_edge[3+n-1], LAT);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.pdm_valid = 1'b0;
        bus.pdm_in    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(bus.pcm_valid), 0);
        check("rst_data", int'(bus.pcm_data), 0);

        // Constant 1s, strobe every clk, 6 frames -> outputs from frames 4..6
        do_reset();
        drive(0, 1, 6 * DECIM);
        flush();
        check_stream("ones", 3, 16384, C1_LAST);
        if (ev_cyc.size() >= 2) check("ones_spacing", ev_cyc[1] - ev_cyc[0], DECIM);
        check("ones_hold_data", int'(bus.pcm_data), C1_LAST);
        check("ones_hold_valid", int'(bus.pcm_valid), 0);

        // Constant 0s
        do_reset();
        drive(1, 1, 6 * DECIM);
        flush();
        check_stream("zeros", 3, -16384, C0_LAST);

        // Alternating 1,0 -> CIC null at Nyquist
        do_reset();
        drive(2, 1, 6 * DECIM);
        flush();
        check_stream("alt", 3, 0, 0);

        // Strobe every 3rd clk
        do_reset();
        drive(0, 3, 5 * DECIM);
        flush();
        check_stream("gap3", 2, 16384, G3_LAST);
        if (ev_cyc.size() >= 2) check("gap3_spacing", ev_cyc[1] - ev_cyc[0], 3 * DECIM);

        // Reset in the middle of frame 5, then restart with all 1s
        do_reset();
        drive(0, 1, 4 * DECIM + 20);
        do_reset();
        check("midrst_valid", int'(bus.pcm_valid), 0);
        check("midrst_data", int'(bus.pcm_data), 0);
        drive(0, 1, 3 * DECIM);
        flush();
        check("midrst_warmup_count", ev_cyc.size(), 0);
        drive(0, 1, DECIM);
        flush();
        check_stream("midrst", 1, 16384, 16384);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
